// File: rtl/refresh_sequencer.sv
`default_nettype none
// refresh_sequencer: drains the scheduler, precharges, issues REF with tRP/tRFC spacing
// and restarts the refresh interval counter.  Rev 1.0
module refresh_sequencer #(
  parameter int tRP       = 16,
  parameter int tRFC      = 420,
  parameter int LATE_MAX  = 64,
  parameter int NUM_BANKS = 16
) (
  input  logic                 CK_t,
  input  logic                 reset,
  input  logic                 refresh_almost,
  input  logic                 refresh_rdy,
  input  logic                 refresh_done,
  input  logic [NUM_BANKS-1:0] bank_open,
  input  logic                 sched_busy,
  input  logic                 cmd_ready,
  output logic                 block_act,
  output logic                 cmd_valid,
  output logic                 cmd_type,
  output logic                 clear_refresh,
  output logic                 ref_active,
  output logic                 ref_late,
  output logic                 done_mismatch
);

  localparam int c_dly_max = (tRP > tRFC) ? tRP : tRFC;
  localparam int c_dly_w   = (c_dly_max > 1) ? $clog2(c_dly_max) : 1;
  localparam int c_late_w  = $clog2(LATE_MAX + 1);

  localparam logic [c_dly_w-1:0]  c_trp_load  = c_dly_w'(tRP - 1);
  localparam logic [c_dly_w-1:0]  c_trfc_load = c_dly_w'(tRFC - 1);
  localparam logic [c_late_w-1:0] c_late_max  = c_late_w'(LATE_MAX);
  localparam logic [c_late_w-1:0] c_late_last = c_late_w'(LATE_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DRAIN     = 3'd1,
    S_PREA      = 3'd2,
    S_TRP_WAIT  = 3'd3,
    S_WAIT_RDY  = 3'd4,
    S_REF       = 3'd5,
    S_TRFC_WAIT = 3'd6,
    S_CLEAR     = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_dly_w-1:0]    r_dly_cnt;
  logic [c_late_w-1:0]   r_late_cnt;
  logic                  r_almost_q;
  logic                  r_rdy_q;
  logic                  r_done_q;

  logic w_start;
  logic w_prea_hs;
  logic w_ref_hs;
  logic w_pre_trfc;
  logic w_late_tick;
  logic w_done_rise;

  // Only a fresh rising flag starts a sequence; levels left over from the last one are ignored.
  assign w_start     = (refresh_almost & ~r_almost_q) | (refresh_rdy & ~r_rdy_q);
  assign w_prea_hs   = (r_state == S_PREA) & cmd_ready;
  assign w_ref_hs    = (r_state == S_REF) & cmd_ready;
  assign w_pre_trfc  = (r_state != S_TRFC_WAIT) & (r_state != S_CLEAR);
  assign w_late_tick = refresh_rdy & w_pre_trfc & ~w_ref_hs;
  assign w_done_rise = refresh_done & ~r_done_q;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (w_start)           w_state_nxt = S_DRAIN;
      S_DRAIN:     if (!sched_busy)       w_state_nxt = (|bank_open) ? S_PREA : S_WAIT_RDY;
      S_PREA:      if (cmd_ready)         w_state_nxt = S_TRP_WAIT;
      S_TRP_WAIT:  if (r_dly_cnt == '0)   w_state_nxt = S_WAIT_RDY;
      S_WAIT_RDY:  if (refresh_rdy)       w_state_nxt = S_REF;
      S_REF:       if (cmd_ready)         w_state_nxt = S_TRFC_WAIT;
      S_TRFC_WAIT: if (r_dly_cnt == '0)   w_state_nxt = S_CLEAR;
      S_CLEAR:                            w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge CK_t) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_dly_cnt     <= '0;
      r_late_cnt    <= '0;
      r_almost_q    <= 1'b0;
      r_rdy_q       <= 1'b0;
      r_done_q      <= 1'b0;
      block_act     <= 1'b0;
      ref_active    <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_type      <= 1'b0;
      clear_refresh <= 1'b1;
      ref_late      <= 1'b0;
      done_mismatch <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_almost_q    <= refresh_almost;
      r_rdy_q       <= refresh_rdy;
      r_done_q      <= refresh_done;
      block_act     <= (w_state_nxt != S_IDLE);
      ref_active    <= (w_state_nxt != S_IDLE);
      cmd_valid     <= (w_state_nxt == S_PREA) | (w_state_nxt == S_REF);
      cmd_type      <= (w_state_nxt == S_REF);
      clear_refresh <= (w_state_nxt == S_CLEAR);

      if (w_prea_hs) begin
        r_dly_cnt <= c_trp_load;
      end else if (w_ref_hs) begin
        r_dly_cnt <= c_trfc_load;
      end else if (((r_state == S_TRP_WAIT) | (r_state == S_TRFC_WAIT)) && (r_dly_cnt != '0)) begin
        r_dly_cnt <= r_dly_cnt - c_dly_w'(1);
      end

      if (w_ref_hs) begin
        r_late_cnt <= '0;
      end else if (w_late_tick && (r_late_cnt != c_late_max)) begin
        r_late_cnt <= r_late_cnt + c_late_w'(1);
      end

      if (w_late_tick && (r_late_cnt == c_late_last)) begin
        ref_late <= 1'b1;
      end

      if (w_done_rise && w_pre_trfc) begin
        done_mismatch <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_refresh_sequencer.sv
`default_nettype none
// tb_refresh_sequencer: directed and randomized refresh sequences checked against
// an interval-based timeline model.  Rev 1.0
module tb_refresh_sequencer;

  localparam int TRP  = 4;
  localparam int TRFC = 10;
  localparam int LATE = 8;

  logic        CK_t = 1'b0;
  logic        reset;
  logic        refresh_almost;
  logic        refresh_rdy;
  logic        refresh_done;
  logic [15:0] bank_open;
  logic        sched_busy;
  logic        cmd_ready;
  logic        block_act;
  logic        cmd_valid;
  logic        cmd_type;
  logic        clear_refresh;
  logic        ref_active;
  logic        ref_late;
  logic        done_mismatch;

  int tests = 0;
  int fails = 0;

  refresh_sequencer #(
    .tRP(TRP), .tRFC(TRFC), .LATE_MAX(LATE), .NUM_BANKS(16)
  ) dut (
    .CK_t(CK_t), .reset(reset),
    .refresh_almost(refresh_almost), .refresh_rdy(refresh_rdy), .refresh_done(refresh_done),
    .bank_open(bank_open), .sched_busy(sched_busy), .cmd_ready(cmd_ready),
    .block_act(block_act), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .clear_refresh(clear_refresh), .ref_active(ref_active),
    .ref_late(ref_late), .done_mismatch(done_mismatch)
  );

  always #5 CK_t = ~CK_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string tag, input int k, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    refresh_almost = 1'b0;
    refresh_rdy    = 1'b0;
    refresh_done   = 1'b0;
    bank_open      = '0;
    sched_busy     = 1'b0;
    cmd_ready      = 1'b0;
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge CK_t); #1;
      check("rst_clear", i, clear_refresh, 1'b1);
      check("rst_block", i, block_act, 1'b0);
      check("rst_valid", i, cmd_valid, 1'b0);
      check("rst_active", i, ref_active, 1'b0);
      check("rst_late", i, ref_late, 1'b0);
      check("rst_mism", i, done_mismatch, 1'b0);
    end
    reset = 1'b0;
    @(posedge CK_t); #1;
    check("rel_clear", 0, clear_refresh, 1'b0);
    check("rel_block", 0, block_act, 1'b0);
    check("rel_valid", 0, cmd_valid, 1'b0);
    @(posedge CK_t); #1;
  endtask

  // Edge 0 carries the refresh_almost pulse. The model derives the edge of each
  // phase boundary from the durations the spec defines and checks outputs per cycle.
  task automatic run_seq(input int b, input bit open, input logic [15:0] open_val,
                         input int pw, input int rw, input int rr, input int dmode,
                         input int abort_off);
    int n, w, m, dd, abort_k, last;
    bit late_exp, bad;
    logic e_blk, e_val, e_clr, e_late, e_mis;
    if (open) begin
      n = b + 2 + pw;
      w = imax(n + TRP + 1, rr);
    end else begin
      n = -100;
      w = imax(b + 2, rr);
    end
    m = w + 1 + rw;
    if (dmode == 1)      dd = m + 1 + $urandom_range(0, TRFC);
    else if (dmode == 2) dd = $urandom_range(0, m);
    else                 dd = -1;
    bad      = (dmode == 2);
    late_exp = (rr + LATE - 1 <= m - 1);
    abort_k  = (abort_off > 0) ? m + abort_off : -1;
    last     = m + TRFC + 3;
    for (int k = 0; k <= last; k++) begin
      refresh_almost = (k == 0);
      refresh_rdy    = (k >= rr) && (k <= m + TRFC + 1);
      sched_busy     = (k >= 1) && (k <= b);
      bank_open      = (k <= b + 1) ? (open ? open_val : 16'h0) : 16'($urandom);
      if (open && k >= b + 2 && k <= n) cmd_ready = (k == n);
      else if (k >= w + 1 && k <= m)    cmd_ready = (k == m);
      else                              cmd_ready = 1'($urandom_range(0, 1));
      refresh_done   = (k == dd);
      reset          = (k == abort_k);
      @(posedge CK_t); #1;
      if (k == abort_k) begin
        check("abort_block", k, block_act, 1'b0);
        check("abort_valid", k, cmd_valid, 1'b0);
        check("abort_clear", k, clear_refresh, 1'b1);
        check("abort_active", k, ref_active, 1'b0);
        check("abort_late", k, ref_late, 1'b0);
        idle_inputs();
        reset = 1'b0;
        @(posedge CK_t); #1;
        check("abort_rel_clear", k, clear_refresh, 1'b0);
        check("abort_rel_block", k, block_act, 1'b0);
        return;
      end
      e_blk  = (k <= m + TRFC);
      e_val  = (open && k >= b + 1 && k <= n - 1) || (k >= w && k <= m - 1);
      e_clr  = (k == m + TRFC);
      e_late = late_exp && (k >= rr + LATE - 1);
      e_mis  = bad && (k >= dd);
      check("block_act", k, block_act, e_blk);
      check("ref_active", k, ref_active, e_blk);
      check("cmd_valid", k, cmd_valid, e_val);
      if (e_val) check("cmd_type", k, cmd_type, (k >= w));
      check("clear_refresh", k, clear_refresh, e_clr);
      check("ref_late", k, ref_late, e_late);
      check("done_mismatch", k, done_mismatch, e_mis);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    do_reset(3);

    // nominal: two banks open, refresh_rdy 20 cycles after refresh_almost
    run_seq(0, 1'b1, 16'h0005, 0, 0, 20, 1, 0);

    // all banks closed, refresh_rdy already high
    do_reset(1);
    run_seq(0, 1'b0, 16'h0000, 0, 0, 0, 0, 0);

    // PREA back-pressured 7 cycles with refresh_rdy high: late flag on 8th cycle
    do_reset(2);
    run_seq(0, 1'b1, 16'h8001, 7, 2, 0, 0, 0);

    // refresh_done pulse while idle
    do_reset(2);
    refresh_done = 1'b1;
    @(posedge CK_t); #1;
    check("idle_mism", 0, done_mismatch, 1'b1);
    check("idle_block", 0, block_act, 1'b0);
    refresh_done = 1'b0;
    @(posedge CK_t); #1;
    check("idle_mism_sticky", 1, done_mismatch, 1'b1);

    // reset during TRFC_WAIT, then a fresh sequence after release
    do_reset(1);
    run_seq(1, 1'b1, 16'h00F0, 1, 1, 3, 0, 4);
    run_seq(0, 1'b1, 16'h0100, 0, 0, 2, 1, 0);

    for (int r = 0; r < 12; r++) begin
      do_reset($urandom_range(1, 3));
      run_seq($urandom_range(0, 3), 1'($urandom_range(0, 1)),
              16'($urandom_range(1, 16'hFFFF)), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 25), $urandom_range(0, 2), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
